fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately, independent of clk.
REQ-004 stall  input  1  hazard-unit hold request for the IF/ID outputs.
REQ-005 redirect  input  1  taken branch/jump from EX; flushes and retargets fetch.
REQ-006 redirect_pc  input  32  redirect target; bits [1:0] are forced to 0 internally.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  32  request address; equals pc_out.
REQ-009 imem_ack  input  1  memory completes the request this cycle; zero-wait allowed.
REQ-010 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-011 pc_out  output  32  current fetch PC register.
REQ-012 id_valid  output  1  IF/ID register holds a live instruction.
REQ-013 id_pc  output  32  PC of the IF/ID instruction.
REQ-014 id_instr  output  32  IF/ID instruction word.
REQ-015 id_pc_plus4  output  32  id_pc+4, registered alongside id_pc.

Function
REQ-016 FSM states: S_RESET, S_FETCH, S_DISCARD; S_RESET advances to S_FETCH on the first edge after reset release.
REQ-017 imem_req = (state is S_FETCH or S_DISCARD) and skid buffer empty; imem_addr held stable while imem_req=1 and imem_ack=0.
REQ-018 Transfer occurs at an edge with imem_req=1 and imem_ack=1.
REQ-019 Transfer in S_FETCH, stall=0, redirect=0, skid empty: IF/ID <= {1, pc_out, imem_rdata, pc_out+4}; pc_out <= pc_out+4; sustains 1 instruction/cycle.
REQ-020 Transfer in S_FETCH with stall=1: IF/ID unchanged; word and its PC captured in the one-entry skid buffer; pc_out <= pc_out+4; imem_req drops next cycle.
REQ-021 stall=0 with skid full: IF/ID <= skid contents, skid emptied in the same edge; imem_req reasserts the following cycle.
REQ-022 stall=1 with no transfer: IF/ID and skid hold.
REQ-023 redirect=1 overrides stall: id_valid <= 0, id_instr <= 32'h0000_0013, skid cleared.
REQ-024 redirect with no request outstanding, or with a transfer at the same edge: returned word dropped; pc_out <= redirect_pc; state S_FETCH.
REQ-025 redirect with imem_req=1, imem_ack=0: state S_DISCARD; pending target <= redirect_pc; pc_out unchanged until ack.
REQ-026 In S_DISCARD: a transfer drops the word, sets pc_out <= pending target, and enters S_FETCH; a further redirect replaces the pending target (latest wins).
REQ-027 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-028 No instruction is ever delivered twice or skipped; delivery order equals fetch order.

Reset
REQ-029 While reset=0: pc_out=RESET_PC, state S_RESET, imem_req=0, id_valid=0, id_pc=0, id_pc_plus4=4, id_instr=32'h0000_0013, skid empty, pending target=0.
REQ-030 Reset asserted mid-request abandons the transaction; an ack during reset is ignored.

Verification
REQ-031 reset=0 for 2 cycles -> values of REQ-029; release -> imem_req=1, imem_addr=0 after one edge.
REQ-032 imem_ack tied 1, imem_rdata=addr^32'hA5A5_0000 -> id_pc 0,4,8,C on consecutive cycles, id_valid held 1, id_instr matching.
REQ-033 stall=1 for 3 cycles while id_pc=4 -> id_pc stays 4, skid takes 8, imem_req=0, pc_out=C; stall=0 -> id_pc=8 next cycle, then C.
REQ-034 ack latency 3, redirect to 0x100 in the first wait cycle -> id_valid=0, late word dropped, next imem_addr=0x100, next delivered id_pc=0x100.
REQ-035 redirect=1 and stall=1 same edge, target 0x40 -> id_valid=0, pc_out=0x40, skid empty.
REQ-036 RESET_PC=32'hFFFF_FFFC, zero-wait memory -> second imem_addr=0, id_pc_plus4 of first instruction=0.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, one-entry skid buffer and redirect discard
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RESET   = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] pc_q;
    logic [31:0] pc_nxt;
    logic [31:0] pend_q;
    logic [31:0] pend_nxt;

    logic        skid_valid_q;
    logic        skid_valid_nxt;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_pc_nxt;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_instr_nxt;

    logic        id_valid_q;
    logic        id_valid_nxt;
    logic [31:0] id_pc_q;
    logic [31:0] id_pc_nxt;
    logic [31:0] id_instr_q;
    logic [31:0] id_instr_nxt;
    logic [31:0] id_pc_plus4_q;
    logic [31:0] id_pc_plus4_nxt;

    logic        xfer;
    logic        outstanding;
    logic [31:0] redirect_tgt;
    logic [31:0] pc_plus4;
    logic [31:0] skid_pc_plus4;

    assign xfer          = imem_req & imem_ack;
    assign outstanding   = imem_req & ~imem_ack;
    assign redirect_tgt  = {redirect_pc[31:2], 2'b00};
    assign pc_plus4      = pc_q + 32'd4;
    assign skid_pc_plus4 = skid_pc_q + 32'd4;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect caught mid-request must wait out the late word
    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (redirect && outstanding) begin
                    state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    state_nxt = outstanding ? S_DISCARD : S_FETCH;
                end else if (xfer) begin
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_RESET;
            end
        endcase
    end

    // Output logic
    always_comb begin
        imem_req = 1'b0;
        case (state)
            S_FETCH, S_DISCARD: imem_req = ~skid_valid_q;
            default:            imem_req = 1'b0;
        endcase
    end

    // Datapath next values
    always_comb begin
        pc_nxt          = pc_q;
        pend_nxt        = pend_q;
        skid_valid_nxt  = skid_valid_q;
        skid_pc_nxt     = skid_pc_q;
        skid_instr_nxt  = skid_instr_q;
        id_valid_nxt    = id_valid_q;
        id_pc_nxt       = id_pc_q;
        id_instr_nxt    = id_instr_q;
        id_pc_plus4_nxt = id_pc_plus4_q;

        if (redirect) begin
            id_valid_nxt   = 1'b0;
            id_instr_nxt   = NOP;
            skid_valid_nxt = 1'b0;
            if (outstanding) begin
                pend_nxt = redirect_tgt;
            end else begin
                pc_nxt = redirect_tgt;
            end
        end else begin
            case (state)
                S_DISCARD: begin
                    if (xfer) begin
                        pc_nxt = pend_q;
                    end
                end
                S_FETCH: begin
                    if (skid_valid_q) begin
                        if (!stall) begin
                            id_valid_nxt    = 1'b1;
                            id_pc_nxt       = skid_pc_q;
                            id_instr_nxt    = skid_instr_q;
                            id_pc_plus4_nxt = skid_pc_plus4;
                            skid_valid_nxt  = 1'b0;
                        end
                    end else if (xfer) begin
                        pc_nxt = pc_plus4;
                        if (stall) begin
                            skid_valid_nxt = 1'b1;
                            skid_pc_nxt    = pc_q;
                            skid_instr_nxt = imem_rdata;
                        end else begin
                            id_valid_nxt    = 1'b1;
                            id_pc_nxt       = pc_q;
                            id_instr_nxt    = imem_rdata;
                            id_pc_plus4_nxt = pc_plus4;
                        end
                    end else if (!stall) begin
                        // Downstream consumed the held word and nothing new arrived
                        id_valid_nxt = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            pend_q        <= 32'h0000_0000;
            skid_valid_q  <= 1'b0;
            skid_pc_q     <= 32'h0000_0000;
            skid_instr_q  <= NOP;
            id_valid_q    <= 1'b0;
            id_pc_q       <= 32'h0000_0000;
            id_instr_q    <= NOP;
            id_pc_plus4_q <= 32'h0000_0004;
        end else begin
            pc_q          <= pc_nxt;
            pend_q        <= pend_nxt;
            skid_valid_q  <= skid_valid_nxt;
            skid_pc_q     <= skid_pc_nxt;
            skid_instr_q  <= skid_instr_nxt;
            id_valid_q    <= id_valid_nxt;
            id_pc_q       <= id_pc_nxt;
            id_instr_q    <= id_instr_nxt;
            id_pc_plus4_q <= id_pc_plus4_nxt;
        end
    end

    assign pc_out      = pc_q;
    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_pc_out;
    logic        w_id_valid;
    logic [31:0] w_id_pc;
    logic [31:0] w_id_instr;
    logic [31:0] w_id_pc_plus4;
    logic        w_stall;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;

    int          checks;
    int          errors;
    int          lat;
    logic [3:0]  wait_cnt;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_pc_plus4 (id_pc_plus4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .stall       (w_stall),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (w_ack),
        .imem_rdata  (w_rdata),
        .pc_out      (w_pc_out),
        .id_valid    (w_id_valid),
        .id_pc       (w_id_pc),
        .id_instr    (w_id_instr),
        .id_pc_plus4 (w_id_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ack arrives on the lat-th cycle of a request
    always @(posedge clk or negedge reset) begin
        if (!reset) wait_cnt <= 4'd0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 4'd1;
        else wait_cnt <= 4'd0;
    end
    assign imem_ack   = imem_req && ((int'(wait_cnt) + 1) >= lat);
    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
    assign w_ack      = w_req;
    assign w_rdata    = w_addr ^ 32'hA5A5_0000;

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got %h want %h", pc_out, 32'h0); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req got %b want 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b want 0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h want %h", id_pc, 32'h0); end
        checks++; if (id_pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_id_pc_plus4 got %h want %h", id_pc_plus4, 32'h4); end
        checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL reset_id_instr got %h want %h", id_instr, 32'h13); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_imem_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL release_imem_addr got %h want %h", imem_addr, 32'h0); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            @(negedge clk);
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", i, id_valid); end
            checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, id_pc, exp_pc); end
            checks++; if (id_instr !== (exp_pc ^ 32'hA5A5_0000)) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", i, id_instr, exp_pc ^ 32'hA5A5_0000); end
            checks++; if (id_pc_plus4 !== exp_pc + 32'd4) begin errors++; $display("FAIL stream_plus4[%0d] got %h want %h", i, id_pc_plus4, exp_pc + 32'd4); end
        end
    endtask

    task automatic test_async_reset();
        lat = 3;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL async_pc_out got %h want %h", pc_out, 32'h0); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_imem_req got %b want 0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL async_id_valid got %b want 0", id_valid); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL async_restart got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, 32'h0); end
        lat = 1;
    endtask

    task automatic test_stall();
        lat = 1;
        do_reset();
        repeat (2) @(negedge clk);
        checks++; if (id_pc !== 32'h4) begin errors++; $display("FAIL stall_pre_pc got %h want %h", id_pc, 32'h4); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (id_pc !== 32'h4) begin errors++; $display("FAIL stall_hold_pc[%0d] got %h want %h", i, id_pc, 32'h4); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b want 0", i, imem_req); end
            checks++; if (pc_out !== 32'hC) begin errors++; $display("FAIL stall_pc_out[%0d] got %h want %h", i, pc_out, 32'hC); end
        end
        stall = 1'b0;
        @(negedge clk);
        checks++; if (id_pc !== 32'h8 || id_valid !== 1'b1) begin errors++; $display("FAIL unstall_skid got pc=%h v=%b want pc=%h v=1", id_pc, id_valid, 32'h8); end
        checks++; if (id_instr !== 32'hA5A5_0008) begin errors++; $display("FAIL unstall_instr got %h want %h", id_instr, 32'hA5A5_0008); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL unstall_req got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, 32'hC); end
        @(negedge clk);
        checks++; if (id_pc !== 32'hC) begin errors++; $display("FAIL unstall_next_pc got %h want %h", id_pc, 32'hC); end
    endtask

    task automatic test_redirect_latency();
        bit seen;
        lat = 3;
        do_reset();
        for (int k = 0; k < 10 && !id_valid; k++) @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++; $display("FAIL lat_first got v=%b pc=%h want v=1 pc=%h", id_valid, id_pc, 32'h0); end
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL lat_flush_valid got %b want 0", id_valid); end
        checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL lat_flush_instr got %h want %h", id_instr, 32'h13); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL lat_addr_held got %h want %h", imem_addr, 32'h4); end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL lat_late_word got v=%b pc=%h want v=0", id_valid, id_pc); end
            if (imem_addr == 32'h100) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL lat_new_addr got %h want %h", imem_addr, 32'h100); end
        for (int k = 0; k < 10 && !id_valid; k++) @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin errors++; $display("FAIL lat_deliver got v=%b pc=%h want v=1 pc=%h", id_valid, id_pc, 32'h100); end
        checks++; if (id_instr !== 32'hA5A5_0100) begin errors++; $display("FAIL lat_deliver_instr got %h want %h", id_instr, 32'hA5A5_0100); end
        lat = 1;
    endtask

    task automatic test_redirect_stall();
        lat = 1;
        do_reset();
        repeat (2) @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rs_skid_full_req got %b want 0", imem_req); end
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rs_valid got %b want 0", id_valid); end
        checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL rs_pc_out got %h want %h", pc_out, 32'h40); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rs_skid_empty_req got %b want 1", imem_req); end
        stall = 1'b0;
        @(negedge clk);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin errors++; $display("FAIL rs_deliver got v=%b pc=%h want v=1 pc=%h", id_valid, id_pc, 32'h40); end
        checks++; if (id_instr !== 32'hA5A5_0040) begin errors++; $display("FAIL rs_deliver_instr got %h want %h", id_instr, 32'hA5A5_0040); end
    endtask

    task automatic test_wrap();
        do_reset();
        checks++; if (w_addr !== 32'hFFFF_FFFC || w_req !== 1'b1) begin errors++; $display("FAIL wrap_first_addr got req=%b addr=%h want req=1 addr=%h", w_req, w_addr, 32'hFFFF_FFFC); end
        @(negedge clk);
        checks++; if (w_addr !== 32'h0) begin errors++; $display("FAIL wrap_second_addr got %h want %h", w_addr, 32'h0); end
        checks++; if (w_id_pc !== 32'hFFFF_FFFC || w_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_id_pc got v=%b pc=%h want v=1 pc=%h", w_id_valid, w_id_pc, 32'hFFFF_FFFC); end
        checks++; if (w_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h want %h", w_id_pc_plus4, 32'h0); end
        @(negedge clk);
        checks++; if (w_id_pc !== 32'h0) begin errors++; $display("FAIL wrap_next_pc got %h want %h", w_id_pc, 32'h0); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        lat           = 1;
        reset         = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        w_stall       = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_async_reset();
        test_stall();
        test_redirect_latency();
        test_redirect_stall();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
